// File: rtl/decode_skid_stage.sv
// rtl/decode_skid_stage.sv - decode stage: bypassed register file feeding a main+skid output buffer
module decode_skid_stage #(
    parameter int XLEN    = 64,
    parameter int NREG    = 32,
    parameter int NRD     = 2,
    parameter int NWB     = 2,
    parameter int INSTR_W = 32,
    localparam int AW     = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [XLEN-1:0]     in_pc,
    input  logic [INSTR_W-1:0]  in_instr,
    input  logic [NRD*AW-1:0]   in_ra,
    input  logic [AW-1:0]       in_dst,
    input  logic                flush,
    input  logic [NWB-1:0]      wb_en,
    input  logic [NWB*AW-1:0]   wb_addr,
    input  logic [NWB*XLEN-1:0] wb_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_pc,
    output logic [INSTR_W-1:0]  out_instr,
    output logic [AW-1:0]       out_dst,
    output logic [NRD*XLEN-1:0] out_src,
    input  logic [AW-1:0]       dbg_ra,
    output logic [XLEN-1:0]     dbg_rd
);

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

    state_t             state;
    logic [XLEN-1:0]    regs [NREG];

    logic [XLEN-1:0]    main_pc, skid_pc;
    logic [INSTR_W-1:0] main_instr, skid_instr;
    logic [AW-1:0]      main_dst, skid_dst;
    logic [AW-1:0]      main_ra [NRD];
    logic [AW-1:0]      skid_ra [NRD];
    logic [XLEN-1:0]    main_src [NRD];
    logic [XLEN-1:0]    skid_src [NRD];

    logic [XLEN-1:0]    in_src [NRD];
    logic [XLEN-1:0]    main_snp [NRD];
    logic [XLEN-1:0]    skid_snp [NRD];
    logic               accept, pop;

    // Later write ports override earlier ones, matching register-file write priority.
    function automatic logic [XLEN-1:0] snoop(input logic [AW-1:0] ra, input logic [XLEN-1:0] cur);
        logic [XLEN-1:0] v;
        v = cur;
        for (int j = 0; j < NWB; j++) begin
            if (wb_en[j] && wb_addr[j*AW +: AW] == ra && ra != '0)
                v = wb_data[j*XLEN +: XLEN];
        end
        return v;
    endfunction

    function automatic logic [XLEN-1:0] rd_port(input logic [AW-1:0] ra);
        return snoop(ra, (ra == '0) ? '0 : regs[ra]);
    endfunction

    assign in_ready  = ~reset & (state != S_TWO);
    assign out_valid = (state != S_EMPTY);
    assign accept    = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready;
    assign out_pc    = main_pc;
    assign out_instr = main_instr;
    assign out_dst   = main_dst;
    assign dbg_rd    = rd_port(dbg_ra);

    always_comb begin
        out_src = '0;
        for (int i = 0; i < NRD; i++) begin
            in_src[i]   = rd_port(in_ra[i*AW +: AW]);
            main_snp[i] = snoop(main_ra[i], main_src[i]);
            skid_snp[i] = snoop(skid_ra[i], skid_src[i]);
            out_src[i*XLEN +: XLEN] = main_src[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++)
                regs[r] <= '0;
        end else begin
            for (int j = 0; j < NWB; j++) begin
                if (wb_en[j] && wb_addr[j*AW +: AW] != '0)
                    regs[wb_addr[j*AW +: AW]] <= wb_data[j*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_EMPTY;
            main_pc    <= '0;
            main_instr <= '0;
            main_dst   <= '0;
            skid_pc    <= '0;
            skid_instr <= '0;
            skid_dst   <= '0;
            for (int i = 0; i < NRD; i++) begin
                main_ra[i]  <= '0;
                main_src[i] <= '0;
                skid_ra[i]  <= '0;
                skid_src[i] <= '0;
            end
        end else begin
            // Held operands track writebacks every cycle so they never go stale.
            for (int i = 0; i < NRD; i++) begin
                main_src[i] <= main_snp[i];
                skid_src[i] <= skid_snp[i];
            end
            if (flush) begin
                state <= S_EMPTY;
            end else begin
                case (state)
                    S_EMPTY: begin
                        if (accept) begin
                            main_pc    <= in_pc;
                            main_instr <= in_instr;
                            main_dst   <= in_dst;
                            for (int i = 0; i < NRD; i++) begin
                                main_ra[i]  <= in_ra[i*AW +: AW];
                                main_src[i] <= in_src[i];
                            end
                            state <= S_ONE;
                        end
                    end
                    S_ONE: begin
                        if (accept && pop) begin
                            main_pc    <= in_pc;
                            main_instr <= in_instr;
                            main_dst   <= in_dst;
                            for (int i = 0; i < NRD; i++) begin
                                main_ra[i]  <= in_ra[i*AW +: AW];
                                main_src[i] <= in_src[i];
                            end
                        end else if (accept) begin
                            skid_pc    <= in_pc;
                            skid_instr <= in_instr;
                            skid_dst   <= in_dst;
                            for (int i = 0; i < NRD; i++) begin
                                skid_ra[i]  <= in_ra[i*AW +: AW];
                                skid_src[i] <= in_src[i];
                            end
                            state <= S_TWO;
                        end else if (pop) begin
                            state <= S_EMPTY;
                        end
                    end
                    S_TWO: begin
                        if (pop) begin
                            main_pc    <= skid_pc;
                            main_instr <= skid_instr;
                            main_dst   <= skid_dst;
                            for (int i = 0; i < NRD; i++) begin
                                main_ra[i]  <= skid_ra[i];
                                main_src[i] <= skid_snp[i];
                            end
                            state <= S_ONE;
                        end
                    end
                    default: state <= S_EMPTY;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_decode_skid_stage.sv
// tb/tb_decode_skid_stage.sv - scoreboard bench for decode_skid_stage
module tb_decode_skid_stage;

    typedef struct packed {
        logic [63:0]      pc;
        logic [31:0]      instr;
        logic [4:0]       dst;
        logic [1:0][4:0]  ra;
        logic [1:0][63:0] src;
    } ent_t;

    logic         clk = 1'b0;
    logic         reset, in_valid, in_ready, flush, out_valid, out_ready;
    logic [63:0]  in_pc, out_pc, dbg_rd;
    logic [31:0]  in_instr, out_instr;
    logic [9:0]   in_ra;
    logic [4:0]   in_dst, out_dst, dbg_ra;
    logic [1:0]   wb_en;
    logic [9:0]   wb_addr;
    logic [127:0] wb_data, out_src;

    logic [4:0]   ra_in [2];
    logic [1:0]   wbe;
    logic [4:0]   wba [2];
    logic [63:0]  wbd [2];

    logic [63:0]  mregs [32];
    ent_t         q[$];
    bit           accepted;
    int           n_pass = 0;
    int           n_checks = 0;

    assign in_ra   = {ra_in[1], ra_in[0]};
    assign wb_en   = wbe;
    assign wb_addr = {wba[1], wba[0]};
    assign wb_data = {wbd[1], wbd[0]};

    always #5 clk = ~clk;

    decode_skid_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .in_ra(in_ra), .in_dst(in_dst),
        .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_instr(out_instr), .out_dst(out_dst), .out_src(out_src),
        .dbg_ra(dbg_ra), .dbg_rd(dbg_rd)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [63:0] msnoop(input logic [4:0] ra, input logic [63:0] cur);
        logic [63:0] v;
        v = cur;
        for (int j = 0; j < 2; j++)
            if (wbe[j] && wba[j] == ra && ra != 5'd0) v = wbd[j];
        return v;
    endfunction

    function automatic logic [63:0] mread(input logic [4:0] ra);
        return msnoop(ra, (ra == 5'd0) ? 64'd0 : mregs[ra]);
    endfunction

    // Check current outputs against the model, then advance model and DUT by one clock.
    task automatic cycle();
        ent_t h, e;
        logic mready, acc, pp;
        #1;
        mready = !reset && q.size() < 2;
        check("in_ready", in_ready, mready);
        check("out_valid", out_valid, q.size() != 0);
        if (q.size() != 0) begin
            h = q[0];
            check("out_pc", out_pc, h.pc);
            check("out_instr", out_instr, h.instr);
            check("out_dst", out_dst, h.dst);
            check("out_src0", out_src[63:0], h.src[0]);
            check("out_src1", out_src[127:64], h.src[1]);
        end
        check("dbg_rd", dbg_rd, mread(dbg_ra));
        acc = in_valid && mready && !flush;
        pp  = q.size() != 0 && out_ready;
        accepted = acc;
        if (reset) begin
            q.delete();
            for (int r = 0; r < 32; r++) mregs[r] = 64'd0;
        end else begin
            if (pp) h = q.pop_front();
            foreach (q[k])
                for (int i = 0; i < 2; i++) q[k].src[i] = msnoop(q[k].ra[i], q[k].src[i]);
            if (acc) begin
                e.pc = in_pc; e.instr = in_instr; e.dst = in_dst;
                for (int i = 0; i < 2; i++) begin
                    e.ra[i]  = ra_in[i];
                    e.src[i] = mread(ra_in[i]);
                end
                q.push_back(e);
            end
            if (flush) q.delete();
            for (int j = 0; j < 2; j++)
                if (wbe[j] && wba[j] != 5'd0) mregs[wba[j]] = wbd[j];
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [63:0] pc, input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] d);
        in_valid = 1'b1; in_pc = pc; in_instr = pc[31:0] ^ 32'hdead_0000;
        ra_in[0] = r0; ra_in[1] = r1; in_dst = d;
    endtask

    task automatic send(input logic [63:0] pc, input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] d);
        drive(pc, r0, r1, d);
        accepted = 1'b0;
        for (int n = 0; n < 20 && !accepted; n++) cycle();
        if (!accepted) check("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic set_wb(input int j, input logic [4:0] a, input logic [63:0] d);
        wbe[j] = 1'b1; wba[j] = a; wbd[j] = d;
    endtask

    task automatic drain(input int n);
        out_ready = 1'b1;
        for (int k = 0; k < n; k++) cycle();
    endtask

    initial begin
        for (int r = 0; r < 32; r++) mregs[r] = 64'd0;
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; dbg_ra = 5'd0;
        in_pc = '0; in_instr = '0; in_dst = '0; ra_in[0] = '0; ra_in[1] = '0;
        wbe = '0; wba[0] = '0; wba[1] = '0; wbd[0] = '0; wbd[1] = '0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        cycle();
        reset = 1'b0;
        check("rst_out_pc", out_pc, 64'd0);
        check("rst_out_src", out_src[63:0] | out_src[127:64], 64'd0);
        cycle();

        // 1: writeback then streaming at full throughput
        set_wb(0, 5'd5, 64'h1234);
        cycle();
        wbe = '0;
        out_ready = 1'b1;
        send(64'h100, 5'd5, 5'd0, 5'd1);
        check("t1_src", out_src[63:0], 64'h1234);
        for (int k = 0; k < 4; k++) send(64'h104 + 4*k, 5'd5, 5'(k), 5'd2);
        drain(3);

        // 2: back-pressure, skid fill, in-order release
        out_ready = 1'b0;
        send(64'h200, 5'd5, 5'd0, 5'd3);
        send(64'h204, 5'd0, 5'd5, 5'd4);
        drive(64'h208, 5'd5, 5'd5, 5'd6);
        cycle(); cycle();
        out_ready = 1'b1;
        send(64'h208, 5'd5, 5'd5, 5'd6);
        drain(3);

        // 3: same-cycle double write with bypass, and x0 stays zero
        set_wb(0, 5'd7, 64'hAA);
        set_wb(1, 5'd7, 64'hBB);
        send(64'h300, 5'd7, 5'd0, 5'd7);
        wbe = '0;
        check("t3_src", out_src[63:0], 64'hBB);
        set_wb(0, 5'd0, 64'hFF);
        cycle();
        wbe = '0;
        dbg_ra = 5'd0; #1 check("t3_x0", dbg_rd, 64'd0);
        dbg_ra = 5'd7; #1 check("t3_x7", dbg_rd, 64'hBB);
        drain(2);

        // 4: snooping of held main and skid entries
        out_ready = 1'b0;
        send(64'h400, 5'd3, 5'd0, 5'd1);
        send(64'h404, 5'd3, 5'd3, 5'd2);
        set_wb(1, 5'd3, 64'h55);
        cycle();
        wbe = '0;
        check("t4_main", out_src[63:0], 64'h55);
        check("t4_valid", out_valid, 64'd1);
        out_ready = 1'b1;
        cycle();
        check("t4_skid0", out_src[63:0], 64'h55);
        check("t4_skid1", out_src[127:64], 64'h55);
        drain(2);

        // 5: flush while full, incoming dropped, writeback kept
        out_ready = 1'b0;
        send(64'h500, 5'd7, 5'd3, 5'd1);
        send(64'h504, 5'd3, 5'd7, 5'd2);
        drive(64'h508, 5'd9, 5'd0, 5'd3);
        flush = 1'b1;
        set_wb(0, 5'd9, 64'h99);
        cycle();
        flush = 1'b0; in_valid = 1'b0; wbe = '0;
        check("t5_valid", out_valid, 64'd0);
        check("t5_ready", in_ready, 64'd1);
        dbg_ra = 5'd9; #1 check("t5_x9", dbg_rd, 64'h99);
        cycle();

        // 6: reset while full
        send(64'h600, 5'd7, 5'd9, 5'd1);
        send(64'h604, 5'd9, 5'd3, 5'd2);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("t6_valid", out_valid, 64'd0);
        check("t6_src", out_src[63:0] | out_src[127:64], 64'd0);
        foreach (ra_in[i]) ra_in[i] = 5'd0;
        for (int a = 3; a < 10; a++) begin
            dbg_ra = 5'(a); #1 check("t6_reg", dbg_rd, 64'd0);
        end
        cycle();

        // random traffic
        for (int k = 0; k < 400; k++) begin
            in_valid = 1'($urandom);
            in_pc = {32'd0, $urandom}; in_instr = $urandom; in_dst = 5'($urandom);
            ra_in[0] = 5'($urandom_range(0, 7)); ra_in[1] = 5'($urandom_range(0, 7));
            out_ready = 1'($urandom);
            flush = ($urandom_range(0, 15) == 0);
            for (int j = 0; j < 2; j++) begin
                wbe[j] = 1'($urandom); wba[j] = 5'($urandom_range(0, 7));
                wbd[j] = {$urandom, $urandom};
            end
            dbg_ra = 5'($urandom_range(0, 7));
            cycle();
        end
        in_valid = 1'b0; flush = 1'b0; wbe = '0;
        drain(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
